// File: rtl/program_loader_pkg.sv
// Shared types and memory-map constants for the boot image loader.
// Imported by the loader top, its byte packer and the bench.
package program_loader_pkg;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam int unsigned RAM_SIZE = 65536;

  localparam int unsigned WIDX_W = 15;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } ld_state_e;

  function automatic logic [31:0] word_addr(
    input logic [31:0]       base,
    input logic [WIDX_W-1:0] idx
  );
    return base + {15'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM program-write bus of the loader.
// slave = loader side, master = host/bench side.
interface program_loader_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        prog_we;
  logic        prog_loading_done;
  logic        load_error;

  modport slave (
    input  in_data,
    input  in_valid,
    input  restart,
    output in_ready,
    output prog_addr,
    output prog_wdata,
    output prog_we,
    output prog_loading_done,
    output load_error
  );

  modport master (
    output in_data,
    output in_valid,
    output restart,
    input  in_ready,
    input  prog_addr,
    input  prog_wdata,
    input  prog_we,
    input  prog_loading_done,
    input  load_error
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs LSB-first bytes into 32-bit words; word_valid_o fires
// combinationally with the 4th byte so the top can register it.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && !clear_i
                        && (lane_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot-time image loader: LEN | data words | CSUM frame in,
// RAM word writes out, sticky done/error flags.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE = RAM_BASE,
  parameter int unsigned MAX_WORDS = RAM_SIZE / 4
) (
  input logic              clk,
  input logic              rst_n,
  program_loader_if.slave  ld
);

  ld_state_e         state_q;
  logic [31:0]       len_q;
  logic [1:0]        hdr_cnt_q;
  logic [WIDX_W-1:0] widx_q;
  logic [7:0]        csum_q;
  logic              in_ready_q;
  logic              done_q;
  logic              err_q;
  logic              prog_we_q;
  logic [31:0]       prog_addr_q;
  logic [31:0]       prog_wdata_q;

  logic        xfer;
  logic [31:0] len_d;
  logic [7:0]  csum_d;
  logic        last_word;
  logic        pk_valid;
  logic [31:0] pk_word;

  // A restart in the same cycle as a transfer drops the byte.
  assign xfer      = ld.in_valid && in_ready_q && !ld.restart;
  assign len_d     = {ld.in_data, len_q[31:8]};
  assign csum_d    = csum_q + ld.in_data;
  assign last_word = ({17'd0, widx_q} == (len_q - 32'd1));

  program_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (ld.restart || (state_q != ST_DATA)),
    .byte_valid_i (xfer && (state_q == ST_DATA)),
    .byte_i       (ld.in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HDR;
      len_q        <= 32'd0;
      hdr_cnt_q    <= 2'd0;
      widx_q       <= '0;
      csum_q       <= 8'd0;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= 32'd0;
      prog_wdata_q <= 32'd0;
    end else begin
      prog_we_q <= 1'b0;
      if (pk_valid) begin
        prog_we_q    <= 1'b1;
        prog_wdata_q <= pk_word;
        prog_addr_q  <= word_addr(LOAD_BASE, widx_q);
      end
      if (ld.restart) begin
        state_q    <= ST_HDR;
        len_q      <= 32'd0;
        hdr_cnt_q  <= 2'd0;
        widx_q     <= '0;
        csum_q     <= 8'd0;
        in_ready_q <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
      end else if (xfer) begin
        case (state_q)
          ST_HDR: begin
            len_q     <= len_d;
            csum_q    <= csum_d;
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd3) begin
              if (len_d > 32'(MAX_WORDS)) begin
                state_q    <= ST_ERR;
                err_q      <= 1'b1;
                in_ready_q <= 1'b0;
              end else if (len_d == 32'd0) begin
                state_q <= ST_CSUM;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            csum_q <= csum_d;
            if (pk_valid) begin
              widx_q <= widx_q + 1'b1;
              if (last_word) state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            in_ready_q <= 1'b0;
            if (ld.in_data == csum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ld.in_ready          = in_ready_q;
  assign ld.prog_we           = prog_we_q;
  assign ld.prog_addr         = prog_addr_q;
  assign ld.prog_wdata        = prog_wdata_q;
  assign ld.prog_loading_done = done_q;
  assign ld.load_error        = err_q;

  a_we_not_done: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(prog_we_q && done_q));

  a_done_err_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(done_q && err_q));

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, checksum,
// length limits, stalls, restart and reset behaviour.
module tb_program_loader;
  import program_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if ld();

  program_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] img[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk)
    if (ld.prog_we) begin
      wa.push_back(ld.prog_addr);
      wd.push_back(ld.prog_wdata);
    end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps)
      while ($urandom_range(0, 1) == 1) idle(1);
    ld.in_data  = b;
    ld.in_valid = 1'b1;
    idle(1);
    ld.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] len,
                            input logic [7:0] delta,
                            input bit gaps);
    logic [7:0] s;
    logic [31:0] w;
    s = 8'd0;
    for (int i = 0; i < 4; i++) begin
      s = s + len[8*i +: 8];
      send_byte(len[8*i +: 8], gaps);
    end
    foreach (img[k]) begin
      w = img[k];
      for (int i = 0; i < 4; i++) begin
        s = s + w[8*i +: 8];
        send_byte(w[8*i +: 8], gaps);
      end
    end
    send_byte(s + delta, gaps);
  endtask

  task automatic pulse_restart();
    ld.restart = 1'b1;
    idle(1);
    ld.restart = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (ld.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 1", ld.in_ready);
    end
    n_cmp++;
    if (ld.prog_loading_done !== 1'b0 || ld.load_error !== 1'b0
        || ld.prog_we !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_flags: done %b err %b we %b want 000",
               ld.prog_loading_done, ld.load_error, ld.prog_we);
    end
    img = '{32'h0000_0001, 32'h0000_0002};
    for (int i = 0; i < 4; i++)
      send_byte((i == 0) ? 8'd2 : 8'd0, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ld.in_ready !== 1'b1 || ld.prog_we !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_ready_we: ready %b we %b want 1 0",
               ld.in_ready, ld.prog_we);
    end
    n_cmp++;
    if (ld.prog_loading_done !== 1'b0 || ld.load_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_flags: done %b err %b want 0 0",
               ld.prog_loading_done, ld.load_error);
    end
    n_cmp++;
    if (wa.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_writes: got %0d want 0", wa.size());
    end
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_good();
    wa.delete(); wd.delete();
    img = '{32'h0000_0013, 32'hDEAD_BEEF};
    send_frame(32'd2, 8'd0, 1'b0);
    n_cmp++;
    if (ld.prog_loading_done !== 1'b1 || ld.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL good_done: done %b ready %b want 1 0",
               ld.prog_loading_done, ld.in_ready);
    end
    idle(2);
    n_cmp++;
    if (wa.size() != 2) begin
      n_bad++;
      $display("FAIL good_nwr: got %0d want 2", wa.size());
    end else begin
      n_cmp++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h0000_0013) begin
        n_bad++;
        $display("FAIL good_w0: got %h/%h want 0/00000013", wa[0], wd[0]);
      end
      n_cmp++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'hDEAD_BEEF) begin
        n_bad++;
        $display("FAIL good_w1: got %h/%h want 4/deadbeef", wa[1], wd[1]);
      end
    end
    pulse_restart();
    n_cmp++;
    if (ld.prog_loading_done !== 1'b0 || ld.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL good_restart: done %b ready %b want 0 1",
               ld.prog_loading_done, ld.in_ready);
    end
  endtask

  task automatic test_bad_csum();
    wa.delete(); wd.delete();
    img = '{32'h0000_0013, 32'hDEAD_BEEF};
    send_frame(32'd2, 8'd1, 1'b0);
    idle(1);
    n_cmp++;
    if (ld.load_error !== 1'b1 || ld.prog_loading_done !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_flags: err %b done %b want 1 0",
               ld.load_error, ld.prog_loading_done);
    end
    n_cmp++;
    if (wa.size() != 2) begin
      n_bad++;
      $display("FAIL bad_nwr: got %0d want 2", wa.size());
    end
    pulse_restart();
    n_cmp++;
    if (ld.load_error !== 1'b0 || ld.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_restart: err %b ready %b want 0 1",
               ld.load_error, ld.in_ready);
    end
  endtask

  task automatic test_len_limits();
    wa.delete(); wd.delete();
    img.delete();
    send_frame(32'd0, 8'd0, 1'b0);
    idle(1);
    n_cmp++;
    if (ld.prog_loading_done !== 1'b1 || wa.size() != 0) begin
      n_bad++;
      $display("FAIL len0: done %b writes %0d want 1 0",
               ld.prog_loading_done, wa.size());
    end
    pulse_restart();
    send_byte(8'h01, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    n_cmp++;
    if (ld.load_error !== 1'b1 || ld.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL lenbig: err %b ready %b want 1 0",
               ld.load_error, ld.in_ready);
    end
    idle(2);
    n_cmp++;
    if (wa.size() != 0 || ld.prog_loading_done !== 1'b0) begin
      n_bad++;
      $display("FAIL lenbig_nwr: writes %0d done %b want 0 0",
               wa.size(), ld.prog_loading_done);
    end
    pulse_restart();
  endtask

  task automatic test_gaps();
    wa.delete(); wd.delete();
    img.delete();
    for (int i = 0; i < 64; i++)
      img.push_back((32'(i) * 32'h0103_0507) ^ 32'hA5C3_0F00);
    send_frame(32'd64, 8'd0, 1'b1);
    idle(2);
    n_cmp++;
    if (ld.prog_loading_done !== 1'b1) begin
      n_bad++;
      $display("FAIL gaps_done: got %b want 1", ld.prog_loading_done);
    end
    n_cmp++;
    if (wa.size() != 64) begin
      n_bad++;
      $display("FAIL gaps_nwr: got %0d want 64", wa.size());
    end
    for (int i = 0; i < 64 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== 32'(4 * i) || wd[i] !== img[i]) begin
        n_bad++;
        $display("FAIL gaps_w%0d: got %h/%h want %h/%h",
                 i, wa[i], wd[i], 32'(4 * i), img[i]);
      end
    end
    pulse_restart();
  endtask

  task automatic test_restart_mid();
    wa.delete(); wd.delete();
    send_byte(8'd2, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'd0, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    ld.in_data  = 8'h55;
    ld.in_valid = 1'b1;
    ld.restart  = 1'b1;
    idle(1);
    ld.in_valid = 1'b0;
    ld.restart  = 1'b0;
    idle(2);
    n_cmp++;
    if (wa.size() != 1) begin
      n_bad++;
      $display("FAIL rmid_nwr: got %0d want 1", wa.size());
    end else begin
      n_cmp++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h1122_3344) begin
        n_bad++;
        $display("FAIL rmid_w0: got %h/%h want 0/11223344", wa[0], wd[0]);
      end
    end
    n_cmp++;
    if (ld.in_ready !== 1'b1 || ld.prog_loading_done !== 1'b0
        || ld.load_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_state: ready %b done %b err %b want 1 0 0",
               ld.in_ready, ld.prog_loading_done, ld.load_error);
    end
    img = '{32'hCAFE_F00D};
    send_frame(32'd1, 8'd0, 1'b0);
    idle(2);
    n_cmp++;
    if (ld.prog_loading_done !== 1'b1 || wa.size() != 2) begin
      n_bad++;
      $display("FAIL rmid_reload: done %b writes %0d want 1 2",
               ld.prog_loading_done, wa.size());
    end else begin
      n_cmp++;
      if (wa[1] !== 32'h0 || wd[1] !== 32'hCAFE_F00D) begin
        n_bad++;
        $display("FAIL rmid_w1: got %h/%h want 0/cafef00d", wa[1], wd[1]);
      end
    end
  endtask

  initial begin
    ld.in_data  = 8'd0;
    ld.in_valid = 1'b0;
    ld.restart  = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    test_reset();
    test_good();
    test_bad_csum();
    test_len_limits();
    test_gaps();
    test_restart_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
